pixel_sequencer: RTL

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

---
 rtl/pixel_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pixel_sequencer.sv
// Raster pixel coordinate generator with valid/ready handshake, single-shot or continuous frames.
// Optional frame counter is built only when SEQ_FRAME_CNT_EN is defined; otherwise frame_cnt is tied to 0.
module pixel_sequencer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CW     = 12
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  input  logic          cont,
  input  logic          stop,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          valid,
  input  logic          ready,
  output logic          sof,
  output logic          eol,
  output logic          busy,
  output logic          done,
  output logic [15:0]   frame_cnt
);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("pixel_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end
    if (HEIGHT < 1) begin : g_bad_height
      $error("pixel_sequencer: HEIGHT must be at least 1");
    end
    if ((2 ** CW) <= WIDTH || (2 ** CW) <= HEIGHT) begin : g_bad_cw
      $error("pixel_sequencer: CW too narrow for WIDTH/HEIGHT");
    end
  endgenerate

  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          stop_pend_q, stop_pend_d;
  logic          done_q, done_d;

  logic xfer;
  logic x_last;
  logic y_last;
  logic final_xfer;
  logic end_run;

  assign xfer       = (state_q == RUN) && ready;
  assign x_last     = (x_q == X_LAST);
  assign y_last     = (y_q == Y_LAST);
  assign final_xfer = xfer && x_last && y_last;
  // A stop arriving on the very cycle of the final transfer still ends this frame.
  assign end_run    = !cont || stop_pend_q || stop;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          if (!x_last) begin
            x_d = x_q + CW'(1);
          end else begin
            x_d = '0;
            if (!y_last) begin
              y_d = y_q + CW'(1);
            end else begin
              y_d = '0;
              if (end_run) begin
                state_d     = IDLE;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

`ifdef SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = final_xfer ? (frame_cnt_q + 16'd1) : frame_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) frame_cnt_q <= 16'd0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign valid = (state_q == RUN);
  assign busy  = (state_q == RUN);
  assign x     = x_q;
  assign y     = y_q;
  assign sof   = valid && (x_q == '0) && (y_q == '0);
  assign eol   = valid && x_last;
  assign done  = done_q;

endmodule
